// File: rtl/blink_sequencer.sv
// Blink sequencer: a prescaled pattern engine that steps an 8-bit LED pattern
// in count, bounce, toggle or hold mode, with a one-cycle tick on each step.
module blink_sequencer #(
  parameter int unsigned PRESCALE = 32'd25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] mode,
  output logic [7:0] blink,
  output logic       tick
);

  localparam int unsigned CW = (PRESCALE > 32'd1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_TERM = CW'(PRESCALE - 32'd1);

  localparam logic [1:0] MODE_COUNT  = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_TOGGLE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    blink_q, blink_d;
  logic          tick_q, tick_d;
  logic [1:0]    mode_q, mode_d;
  dir_e          dir_q, dir_d;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  // State register; reset forces the idle pattern immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      blink_q <= 8'h00;
      tick_q  <= 1'b0;
      mode_q  <= MODE_COUNT;
      dir_q   <= DIR_LEFT;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      tick_q  <= tick_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
    end
  end

  // Next state: a mode change outranks pause, which outranks a pattern step.
  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    tick_d  = 1'b0;
    mode_d  = mode_q;
    dir_d   = dir_q;
    if (mode != mode_q) begin
      mode_d = mode;
      cnt_d  = '0;
      case (mode)
        MODE_COUNT:  blink_d = 8'h00;
        MODE_BOUNCE: begin
          blink_d = 8'h01;
          dir_d   = DIR_LEFT;
        end
        MODE_TOGGLE: blink_d = 8'h55;
        MODE_HOLD:   blink_d = blink_q;
        default:     blink_d = blink_q;
      endcase
    end else if (!enable) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_TERM) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      case (mode_q)
        MODE_COUNT:  blink_d = blink_q + 8'h01;
        MODE_BOUNCE: begin
          // A corrupted pattern restarts the bounce from the right-hand end.
          if (!is_onehot(blink_q)) begin
            blink_d = 8'h01;
            dir_d   = DIR_LEFT;
          end else if (dir_q == DIR_LEFT) begin
            if (blink_q == 8'h80) begin
              blink_d = 8'h40;
              dir_d   = DIR_RIGHT;
            end else begin
              blink_d = blink_q << 1;
            end
          end else begin
            if (blink_q == 8'h01) begin
              blink_d = 8'h02;
              dir_d   = DIR_LEFT;
            end else begin
              blink_d = blink_q >> 1;
            end
          end
        end
        MODE_TOGGLE: blink_d = ~blink_q;
        MODE_HOLD:   blink_d = blink_q;
        default:     blink_d = blink_q;
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1'b1);
    end
  end

  assign blink = blink_q;
  assign tick  = tick_q;

endmodule

// File: doc/blink_sequencer.md
BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 25000000, clk cycles per pattern step (legal range 1 to 2^32-1).
REQ-002 SHALL have port clk, input, 1, free-running 50 MHz system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port enable, input, 1, run/pause control, synchronous to clk.
REQ-005 SHALL have port mode, input, 2, pattern select: 00 count, 01 bounce, 10 toggle, 11 hold.
REQ-006 SHALL have port blink, output, 8, registered LED pattern.
REQ-007 SHALL have port tick, output, 1, registered one-cycle pulse marking each pattern step.

Function
REQ-008 SHALL hold a prescale counter of width max(1,$clog2(PRESCALE)) that counts 0 to PRESCALE-1 and then wraps to 0.
REQ-009 SHALL, when enable=1 and counter==PRESCALE-1 at a rising edge, set counter to 0, drive tick=1 for exactly that next cycle, and apply one pattern step to blink at the same edge.
REQ-010 SHALL, with PRESCALE=1, assert tick on every enabled cycle and step blink every cycle.
REQ-011 SHALL, when enable=0, clear counter to 0, hold tick=0, and hold blink, direction and mode_q unchanged.
REQ-012 SHALL step count mode (00) as blink+1 modulo 256, so 0xFF wraps to 0x00.
REQ-013 SHALL step bounce mode (01) with direction state LEFT/RIGHT: LEFT shifts blink left; when blink==0x80 it sets blink to 0x40 and direction to RIGHT.
REQ-014 SHALL step bounce mode RIGHT by shifting blink right; when blink==0x01 it sets blink to 0x02 and direction to LEFT.
REQ-015 SHALL, in bounce mode, load blink=0x01 and direction LEFT on any step where blink is not one-hot (recovery).
REQ-016 SHALL step toggle mode (10) as blink <= ~blink.
REQ-017 SHALL leave blink unchanged in hold mode (11); tick still pulses at the prescale rate.
REQ-018 SHALL register the applied mode in mode_q; a mode change is detected when mode != mode_q at a rising edge, regardless of enable.
REQ-019 SHALL, on the edge where a mode change is detected, set mode_q to mode, counter to 0 and tick to 0, and load the seed for the new mode: 00 gives 0x00; 01 gives 0x01 with LEFT; 10 gives 0x55; 11 keeps blink.
REQ-020 SHALL give a mode change priority over a coincident tick: no step is applied and no tick pulse is produced on that edge.
REQ-021 SHALL produce the first step after a mode change or re-enable exactly PRESCALE enabled cycles later.

Reset
REQ-022 SHALL, while rst=0, asynchronously force blink=0x00, tick=0, counter=0, mode_q=00 and direction LEFT.
REQ-023 SHALL resume counting on the first rising edge after rst deasserts; if mode!=00 at that edge, the REQ-019 reload applies.

Verification (PRESCALE=4)
REQ-024 SHALL verify count mode: reset release with mode=00 and enable=1 -> tick every 4th cycle, blink 0x00,0x01,0x02,...; after 256 ticks blink=0x00 again.
REQ-025 SHALL verify bounce mode: switch to mode=01 -> blink=0x01 at the next edge, then 0x02,0x04,...,0x80,0x40,...,0x01,0x02, one step per tick.
REQ-026 SHALL verify toggle mode: switch to mode=10 -> blink=0x55, then 0xAA, 0x55, alternating on each tick; mode=11 -> blink frozen while tick continues.
REQ-027 SHALL verify pause: drop enable with the counter at 2 -> blink holds and tick stays 0; on re-enable the first tick and step occur 4 cycles later.
REQ-028 SHALL verify mode change on a tick edge: change mode on the edge where counter==3 -> seed loaded, tick=0, next tick 4 cycles later.
REQ-029 SHALL verify mid-run reset: pull rst low between edges with blink=0x37 -> blink=0x00 and tick=0 immediately, without waiting for a clock edge.
